block_serializer: RTL and testbench

Sits directly downstream of the multiple-retirement stage, between it and the trace encoder. It accepts up to N completed trace blocks per cycle: per-lane iretire, ilastsize, itype and iaddr, plus shared cause, tval and priv. It buffers them in a circular store and presents them one block per cycle on a valid/ready interface, so the encoder can apply backpressure. A whole group is dropped, and overflow is flagged, when space is insufficient.

---
 rtl/block_serializer.sv | 143 ++++++++++++++
 tb/tb_block_serializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_serializer.sv
// Trace block serializer: accepts up to N retirement blocks per cycle into a circular
// store and replays them one per cycle to the trace encoder over valid/ready.

package mure_pkg;
    parameter int XLEN        = 32;
    parameter int IRETIRE_LEN = 14;
    parameter int ITYPE_LEN   = 4;
    parameter int CAUSE_LEN   = 5;
    parameter int PRIV_LEN    = 2;
endpackage

module block_serializer #(
    parameter int N     = 1,
    parameter int DEPTH = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [N-1:0]                              valid_i,
    input  logic [N-1:0][mure_pkg::IRETIRE_LEN-1:0]   iretire_i,
    input  logic [N-1:0]                              ilastsize_i,
    input  logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]     itype_i,
    input  logic [N-1:0][mure_pkg::XLEN-1:0]          iaddr_i,
    input  logic [mure_pkg::CAUSE_LEN-1:0]            cause_i,
    input  logic [mure_pkg::XLEN-1:0]                 tval_i,
    input  logic [mure_pkg::PRIV_LEN-1:0]             priv_i,
    output logic                                      valid_o,
    input  logic                                      ready_i,
    output logic [mure_pkg::IRETIRE_LEN-1:0]          iretire_o,
    output logic                                      ilastsize_o,
    output logic [mure_pkg::ITYPE_LEN-1:0]            itype_o,
    output logic [mure_pkg::XLEN-1:0]                 iaddr_o,
    output logic [mure_pkg::CAUSE_LEN-1:0]            cause_o,
    output logic [mure_pkg::XLEN-1:0]                 tval_o,
    output logic [mure_pkg::PRIV_LEN-1:0]             priv_o,
    output logic                                      overflow_o,
    output logic                                      overflow_sticky_o,
    input  logic                                      overflow_clr_i,
    output logic [$clog2(DEPTH):0]                    count_o
);
    import mure_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IRETIRE_LEN-1:0] memIretire_q   [DEPTH];
    logic                   memIlastsize_q [DEPTH];
    logic [ITYPE_LEN-1:0]   memItype_q     [DEPTH];
    logic [XLEN-1:0]        memIaddr_q     [DEPTH];
    logic [CAUSE_LEN-1:0]   memCause_q     [DEPTH];
    logic [XLEN-1:0]        memTval_q      [DEPTH];
    logic [PRIV_LEN-1:0]    memPriv_q      [DEPTH];

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  sticky_q, sticky_d;
    logic [CW-1:0]         pushCnt;
    logic [CW-1:0]         space;
    logic                  accept;
    logic                  pop;
    logic [PW-1:0]         offs;
    logic [N-1:0][PW-1:0]  laneSlot;

    // Valid lanes are packed into consecutive slots; offs counts valid lanes below lane i.
    always_comb begin
        pushCnt  = '0;
        offs     = '0;
        laneSlot = '0;
        for (int i = 0; i < N; i++) begin
            laneSlot[i] = wptr_q + offs;
            if (valid_i[i]) begin
                pushCnt = pushCnt + CW'(1);
                offs    = offs + PW'(1);
            end
        end
        space      = CW'(DEPTH) - count_q;
        accept     = (pushCnt != '0) && (space >= pushCnt);
        overflow_o = (pushCnt != '0) && !accept;
        pop        = (count_q != '0) && ready_i;
        wptr_d     = accept ? (wptr_q + pushCnt[PW-1:0]) : wptr_q;
        rptr_d     = rptr_q + PW'(pop);
        count_d    = count_q + (accept ? pushCnt : '0) - CW'(pop);
        sticky_d   = overflow_o ? 1'b1 : (overflow_clr_i ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage needs no reset; cause/tval only carry meaning for exception/interrupt blocks.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (accept && valid_i[i]) begin
                memIretire_q[laneSlot[i]]   <= iretire_i[i];
                memIlastsize_q[laneSlot[i]] <= ilastsize_i[i];
                memItype_q[laneSlot[i]]     <= itype_i[i];
                memIaddr_q[laneSlot[i]]     <= iaddr_i[i];
                memPriv_q[laneSlot[i]]      <= priv_i;
                if (itype_i[i] == ITYPE_LEN'(1) || itype_i[i] == ITYPE_LEN'(2)) begin
                    memCause_q[laneSlot[i]] <= cause_i;
                    memTval_q[laneSlot[i]]  <= tval_i;
                end else begin
                    memCause_q[laneSlot[i]] <= '0;
                    memTval_q[laneSlot[i]]  <= '0;
                end
            end
        end
    end

    always_comb begin
        iretire_o   = '0;
        ilastsize_o = 1'b0;
        itype_o     = '0;
        iaddr_o     = '0;
        cause_o     = '0;
        tval_o      = '0;
        priv_o      = '0;
        if (count_q != '0) begin
            iretire_o   = memIretire_q[rptr_q];
            ilastsize_o = memIlastsize_q[rptr_q];
            itype_o     = memItype_q[rptr_q];
            iaddr_o     = memIaddr_q[rptr_q];
            cause_o     = memCause_q[rptr_q];
            tval_o      = memTval_q[rptr_q];
            priv_o      = memPriv_q[rptr_q];
        end
    end

    assign valid_o           = (count_q != '0);
    assign count_o           = count_q;
    assign overflow_sticky_o = sticky_q;

endmodule

// File: tb/tb_block_serializer.sv
// Randomised scoreboard bench for block_serializer: a queue-based reference model
// predicts every head block, occupancy and overflow flag.

module tb_block_serializer;
    import mure_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                             clk_i = 1'b0;
    logic                             rst_ni = 1'b0;
    logic [N-1:0]                     valid_i = '0;
    logic [N-1:0][IRETIRE_LEN-1:0]    iretire_i = '0;
    logic [N-1:0]                     ilastsize_i = '0;
    logic [N-1:0][ITYPE_LEN-1:0]      itype_i = '0;
    logic [N-1:0][XLEN-1:0]           iaddr_i = '0;
    logic [CAUSE_LEN-1:0]             cause_i = '0;
    logic [XLEN-1:0]                  tval_i = '0;
    logic [PRIV_LEN-1:0]              priv_i = '0;
    logic                             valid_o;
    logic                             ready_i = 1'b0;
    logic [IRETIRE_LEN-1:0]           iretire_o;
    logic                             ilastsize_o;
    logic [ITYPE_LEN-1:0]             itype_o;
    logic [XLEN-1:0]                  iaddr_o;
    logic [CAUSE_LEN-1:0]             cause_o;
    logic [XLEN-1:0]                  tval_o;
    logic [PRIV_LEN-1:0]              priv_o;
    logic                             overflow_o;
    logic                             overflow_sticky_o;
    logic                             overflow_clr_i = 1'b0;
    logic [CW-1:0]                    count_o;

    block_serializer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .valid_o(valid_o), .ready_i(ready_i), .iretire_o(iretire_o),
        .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .overflow_o(overflow_o), .overflow_sticky_o(overflow_sticky_o),
        .overflow_clr_i(overflow_clr_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        iaddr;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
    } blk_t;

    blk_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   lastPushed = 0;
    bit   expOvf = 0;
    bit   expSticky = 0;
    bit   prevOvf = 0;
    bit   prevClr = 0;
    bit   monEn = 0;

    logic [N-1:0][IRETIRE_LEN-1:0] stIretire = '0;
    logic [N-1:0]                  stIlastsize = '0;
    logic [N-1:0][ITYPE_LEN-1:0]   stItype = '0;
    logic [N-1:0][XLEN-1:0]        stIaddr = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setLane(input int l, input int ir, input bit ls, input int it, input logic [XLEN-1:0] addr);
        stIretire[l]   = IRETIRE_LEN'(ir);
        stIlastsize[l] = ls;
        stItype[l]     = ITYPE_LEN'(it);
        stIaddr[l]     = addr;
    endtask

    // One cycle of stimulus; the reference model decides acceptance from the
    // occupancy at cycle start, which is the queue size at this point.
    task automatic applyStimulus(input logic [N-1:0] v, input int c, input logic [XLEN-1:0] tv,
                                 input int pv, input bit rdy, input bit clr);
        int occ;
        int k;
        blk_t b;
        @(posedge clk_i);
        #1;
        expSticky = prevOvf ? 1'b1 : (prevClr ? 1'b0 : expSticky);
        valid_i        = v;
        iretire_i      = stIretire;
        ilastsize_i    = stIlastsize;
        itype_i        = stItype;
        iaddr_i        = stIaddr;
        cause_i        = CAUSE_LEN'(c);
        tval_i         = tv;
        priv_i         = PRIV_LEN'(pv);
        ready_i        = rdy;
        overflow_clr_i = clr;
        occ = expQ.size();
        k = $countones(v);
        lastPushed = 0;
        expOvf = 0;
        if (k > 0 && (DEPTH - occ) >= k) begin
            for (int l = 0; l < N; l++) begin
                if (v[l]) begin
                    b.iretire   = stIretire[l];
                    b.ilastsize = stIlastsize[l];
                    b.itype     = stItype[l];
                    b.iaddr     = stIaddr[l];
                    b.priv      = PRIV_LEN'(pv);
                    if (stItype[l] == 1 || stItype[l] == 2) begin
                        b.cause = CAUSE_LEN'(c);
                        b.tval  = tv;
                    end else begin
                        b.cause = '0;
                        b.tval  = '0;
                    end
                    expQ.push_back(b);
                end
            end
            lastPushed = k;
        end else if (k > 0) begin
            expOvf = 1;
        end
        prevOvf = expOvf;
        prevClr = clr;
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) applyStimulus('0, 0, '0, 0, rdy, 1'b0);
    endtask

    task automatic randLanes();
        for (int l = 0; l < N; l++)
            setLane(l, $urandom_range(0, 16383), 1'($urandom), $urandom_range(0, 7), $urandom);
    endtask

    // Monitor: compares the presented head against the oldest model entry
    // that existed before this cycle's push, then retires it on a handshake.
    always @(negedge clk_i) begin
        if (monEn) begin
            int occ;
            occ = expQ.size() - lastPushed;
            checkOutput("count", 64'(count_o), 64'(occ));
            checkOutput("valid", 64'(valid_o), 64'(occ != 0));
            checkOutput("overflow", 64'(overflow_o), 64'(expOvf));
            checkOutput("sticky", 64'(overflow_sticky_o), 64'(expSticky));
            if (occ > 0) begin
                checkOutput("iaddr", 64'(iaddr_o), 64'(expQ[0].iaddr));
                checkOutput("iretire", 64'(iretire_o), 64'(expQ[0].iretire));
                checkOutput("ilastsize", 64'(ilastsize_o), 64'(expQ[0].ilastsize));
                checkOutput("itype", 64'(itype_o), 64'(expQ[0].itype));
                checkOutput("cause", 64'(cause_o), 64'(expQ[0].cause));
                checkOutput("tval", 64'(tval_o), 64'(expQ[0].tval));
                checkOutput("priv", 64'(priv_o), 64'(expQ[0].priv));
                if (ready_i) void'(expQ.pop_front());
            end else begin
                checkOutput("idle iaddr", 64'(iaddr_o), 64'd0);
                checkOutput("idle tval", 64'(tval_o), 64'd0);
                checkOutput("idle misc", 64'({iretire_o, ilastsize_o, itype_o, cause_o, priv_o}), 64'd0);
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset valid", 64'(valid_o), 64'd0);
        checkOutput("reset count", 64'(count_o), 64'd0);
        checkOutput("reset sticky", 64'(overflow_sticky_o), 64'd0);
        checkOutput("reset iaddr", 64'(iaddr_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 monEn = 1;

        // Single lane block, cause/tval must be masked because itype is 0.
        setLane(0, 5, 0, 0, 32'h8000_0000);
        applyStimulus(2'b01, 3, 32'h1234, 3, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Two lanes held under backpressure, then drained in lane order.
        setLane(0, 1, 1, 0, 32'h100);
        setLane(1, 2, 0, 0, 32'h200);
        applyStimulus(2'b11, 0, '0, 1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Exception block followed by a non-trap block in the same group.
        setLane(0, 7, 0, 1, 32'h400);
        setLane(1, 3, 1, 4, 32'h404);
        applyStimulus(2'b11, 2, 32'hDEAD, 3, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill to 7, drop a two-lane group, hold sticky, then clear it.
        for (int g = 0; g < 3; g++) begin
            randLanes();
            applyStimulus(2'b11, 1, 32'h55, 0, 1'b0, 1'b0);
        end
        randLanes();
        applyStimulus(2'b10, 2, 32'h66, 1, 1'b0, 1'b0);
        randLanes();
        applyStimulus(2'b11, 2, 32'h77, 1, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus('0, 0, '0, 0, 1'b0, 1'b1);
        idle(1, 1'b0);
        randLanes();
        applyStimulus(2'b11, 1, 32'h88, 2, 1'b0, 1'b1);
        idle(2, 1'b0);
        randLanes();
        applyStimulus(2'b01, 1, 32'h99, 2, 1'b0, 1'b0);
        randLanes();
        applyStimulus(2'b01, 1, 32'h99, 2, 1'b1, 1'b1);
        idle(10, 1'b1);

        // Streamed groups with toggling ready to cross the pointer wrap.
        for (int g = 0; g < 20; g++) begin
            randLanes();
            applyStimulus(2'b11, $urandom_range(0, 31), $urandom, $urandom_range(0, 3), (g % 2) == 0, 1'b0);
        end
        idle(12, 1'b1);

        for (int c = 0; c < 300; c++) begin
            randLanes();
            applyStimulus(N'($urandom), $urandom_range(0, 31), $urandom, $urandom_range(0, 3),
                          ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        idle(12, 1'b1);

        // Build occupancy 5 and reset asynchronously mid-cycle.
        randLanes();
        applyStimulus(2'b11, 0, '0, 0, 1'b0, 1'b0);
        randLanes();
        applyStimulus(2'b11, 0, '0, 0, 1'b0, 1'b0);
        randLanes();
        applyStimulus(2'b01, 0, '0, 0, 1'b0, 1'b0);
        idle(1, 1'b0);
        #2;
        monEn = 0;
        valid_i = '0;
        rst_ni = 1'b0;
        #1;
        checkOutput("async rst valid", 64'(valid_o), 64'd0);
        checkOutput("async rst count", 64'(count_o), 64'd0);
        checkOutput("async rst sticky", 64'(overflow_sticky_o), 64'd0);
        expQ.delete();
        lastPushed = 0;
        expOvf = 0;
        expSticky = 0;
        prevOvf = 0;
        prevClr = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1 monEn = 1;
        setLane(0, 9, 1, 2, 32'hCAFE_0000);
        setLane(1, 4, 0, 0, 32'hCAFE_0004);
        applyStimulus(2'b11, 5, 32'hBEEF, 2, 1'b1, 1'b0);
        idle(4, 1'b1);

        monEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
